// File: rtl/fp_i2c_job_scheduler.sv
// rtl/fp_i2c_job_scheduler.sv - two-requester FP job scheduler feeding one I2C master
//
// Purpose: round-robin arbitrates 66-bit {op, A, B} commands from two requesters,
// then runs one job at a time: drives the shared FP unit, captures its result into
// a 104-bit I2C frame, launches the I2C master, waits for completion or timeout and
// reports a per-job status.
//
// Ports:
//   clk, reset                  clock; asynchronous active-high reset
//   req_valid[1:0]              per-requester command valid
//   req_cmd0/req_cmd1[65:0]     {op[1:0], A[31:0], B[31:0]}
//   req_ready[1:0]              one-hot accept (combinational in IDLE)
//   fp_op/fp_a/fp_b             operands to the FP unit, held until next handshake
//   fp_result[31:0]             FP unit result (combinational from fp_*)
//   i2c_ready                   I2C master idle
//   i2c_frame[103:0]            {ACK_START, op, A, B, result}
//   i2c_enable                  one-cycle launch strobe
//   i2c_complete                I2C transfer finished
//   busy, done, done_id         job in progress / finished pulse / finished requester
//   status[1:0]                 00 ok, 01 bad opcode, 10 I2C timeout

module fp_i2c_job_scheduler #(
  parameter int unsigned FP_WAIT   = 2,
  parameter int unsigned TIMEOUT   = 1000000,
  parameter logic [5:0]  ACK_START = 6'b111111
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req_valid,
  input  logic [65:0]  req_cmd0,
  input  logic [65:0]  req_cmd1,
  output logic [1:0]   req_ready,
  output logic [1:0]   fp_op,
  output logic [31:0]  fp_a,
  output logic [31:0]  fp_b,
  input  logic [31:0]  fp_result,
  input  logic         i2c_ready,
  output logic [103:0] i2c_frame,
  output logic         i2c_enable,
  input  logic         i2c_complete,
  output logic         busy,
  output logic         done,
  output logic         done_id,
  output logic [1:0]   status
);

  localparam int unsigned CNT_MAX = (TIMEOUT > FP_WAIT) ? TIMEOUT : FP_WAIT;
  localparam int          CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] FP_LAST = CW'(FP_WAIT - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_SEND,
    S_WAIT_CMPL,
    S_DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           last_grant;
  logic           cur_id;
  logic [CW-1:0]  cnt;
  logic [1:0]     grant;
  logic           grant_id;
  logic [65:0]    sel_cmd;
  logic           fp_last;
  logic           wait_timeout;

  assign grant_id     = grant[1];
  assign sel_cmd      = grant_id ? req_cmd1 : req_cmd0;
  assign fp_last      = (cnt == FP_LAST);
  assign wait_timeout = (cnt >= TO_LAST);

  always_comb begin
    state_nxt  = state;
    grant      = 2'b00;
    i2c_enable = 1'b0;
    case (state)
      S_IDLE: begin
        // Grant is suppressed while reset is held so every output reads 0.
        if (!reset) begin
          case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
          endcase
        end
        if (grant != 2'b00) begin
          state_nxt = (sel_cmd[65:64] == 2'b11) ? S_DONE : S_EXEC;
        end
      end
      S_EXEC: begin
        if (fp_last) state_nxt = S_SEND;
      end
      S_SEND: begin
        if (i2c_ready) begin
          i2c_enable = 1'b1;
          state_nxt  = S_WAIT_CMPL;
        end
      end
      S_WAIT_CMPL: begin
        if (i2c_complete || wait_timeout) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign req_ready = grant;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign done_id   = cur_id;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      cur_id     <= 1'b0;
      cnt        <= '0;
      fp_op      <= 2'b00;
      fp_a       <= 32'h0;
      fp_b       <= 32'h0;
      i2c_frame  <= 104'h0;
      status     <= 2'b00;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (grant != 2'b00) begin
            cur_id     <= grant_id;
            last_grant <= grant_id;
            fp_op      <= sel_cmd[65:64];
            fp_a       <= sel_cmd[63:32];
            fp_b       <= sel_cmd[31:0];
            cnt        <= '0;
            if (sel_cmd[65:64] == 2'b11) status <= 2'b01;
          end
        end
        S_EXEC: begin
          cnt <= cnt + 1'b1;
          if (fp_last) i2c_frame <= {ACK_START, fp_op, fp_a, fp_b, fp_result};
        end
        S_SEND: begin
          // Counter tracks cycles since the launch strobe, so the timeout
          // lands TIMEOUT cycles after i2c_enable.
          cnt <= CW'(1);
        end
        S_WAIT_CMPL: begin
          cnt <= cnt + 1'b1;
          if (i2c_complete)      status <= 2'b00;
          else if (wait_timeout) status <= 2'b10;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_i2c_job_scheduler.sv
// tb/tb_fp_i2c_job_scheduler.sv - scoreboard bench for fp_i2c_job_scheduler
module tb_fp_i2c_job_scheduler;

  localparam int FP_WAIT = 2;
  localparam int TIMEOUT = 50;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   req_valid = 2'b00;
  logic [65:0]  req_cmd0 = '0;
  logic [65:0]  req_cmd1 = '0;
  logic [1:0]   req_ready;
  logic [1:0]   fp_op;
  logic [31:0]  fp_a;
  logic [31:0]  fp_b;
  logic [31:0]  fp_result;
  logic         i2c_ready = 1'b1;
  logic [103:0] i2c_frame;
  logic         i2c_enable;
  logic         i2c_complete = 1'b0;
  logic         busy;
  logic         done;
  logic         done_id;
  logic [1:0]   status;

  always #5 clk = ~clk;

  fp_i2c_job_scheduler #(
    .FP_WAIT(FP_WAIT), .TIMEOUT(TIMEOUT), .ACK_START(6'h3F)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_cmd0(req_cmd0),
    .req_cmd1(req_cmd1), .req_ready(req_ready), .fp_op(fp_op), .fp_a(fp_a),
    .fp_b(fp_b), .fp_result(fp_result), .i2c_ready(i2c_ready),
    .i2c_frame(i2c_frame), .i2c_enable(i2c_enable), .i2c_complete(i2c_complete),
    .busy(busy), .done(done), .done_id(done_id), .status(status)
  );

  // Stand-in FP unit: exact for the 1.0 + 2.0 case, integer arithmetic otherwise.
  function automatic logic [31:0] fp_unit_stub(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
    case (op)
      2'b00:   return (a == 32'h3F800000 && b == 32'h40000000) ? 32'h40400000 : a + b;
      2'b01:   return a - b;
      2'b10:   return a * b;
      default: return 32'h0;
    endcase
  endfunction

  assign fp_result = fp_unit_stub(fp_op, fp_a, fp_b);

  typedef struct {
    logic         id;
    logic [1:0]   op;
    logic [1:0]   status;
    logic [103:0] frame;
    int           delay;
    int           en_off;
  } job_t;

  job_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic finish_tb();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  // ---------------- reference model / stimulus state ----------------
  bit          pend[2];
  logic [65:0] pcmd[2];
  int          pdelay[2];
  int          pstall[2];
  bit          mlast = 1'b1;
  int          cur_delay = -1;

  task automatic drive_reqs();
    req_valid = {pend[1], pend[0]};
    req_cmd0  = pcmd[0];
    req_cmd1  = pcmd[1];
  endtask

  task automatic new_cmd(input int i, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int delay, input int stall);
    pend[i]   = 1'b1;
    pcmd[i]   = {op, a, b};
    pdelay[i] = delay;
    pstall[i] = stall;
  endtask

  task automatic rand_cmd(input int i);
    logic [1:0] op;
    int delay;
    int stall;
    op    = 2'($urandom_range(0, 3));
    delay = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, 15));
    stall = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 5)) : 0;
    new_cmd(i, op, $urandom, $urandom, delay, stall);
  endtask

  task automatic issue_job();
    int   w;
    job_t j;
    bit   seen;
    if (pend[0] && pend[1]) w = mlast ? 0 : 1;
    else                    w = pend[1] ? 1 : 0;
    mlast    = w[0];
    j.id     = w[0];
    j.op     = pcmd[w][65:64];
    j.delay  = pdelay[w];
    j.status = (j.op == 2'b11) ? 2'b01 :
               (j.delay < 1 || j.delay >= TIMEOUT) ? 2'b10 : 2'b00;
    j.frame  = {6'h3F, j.op, pcmd[w][63:32], pcmd[w][31:0],
                fp_unit_stub(j.op, pcmd[w][63:32], pcmd[w][31:0])};
    j.en_off = 1 + FP_WAIT + pstall[w];
    exp_q.push_back(j);
    cur_delay = pdelay[w];
    drive_reqs();
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if ((req_ready & req_valid) != 2'b00) seen = 1'b1;
    end
    check("handshake_seen", seen, 1);
    if (!seen) finish_tb();
    @(posedge clk);
    #1;
    pend[w] = 1'b0;
    pcmd[w] = {2'($urandom), $urandom, $urandom};
    drive_reqs();
    if (pstall[w] > 0 && j.op != 2'b11) begin
      i2c_ready = 1'b0;
      repeat (FP_WAIT + pstall[w]) @(posedge clk);
      #1 i2c_ready = 1'b1;
    end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < TIMEOUT + 100 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    if (!seen) finish_tb();
  endtask

  task automatic run_round();
    issue_job();
    wait_done();
  endtask

  task automatic drain();
    while (pend[0] || pend[1]) run_round();
  endtask

  // ---------------- I2C master responder ----------------
  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (i2c_enable === 1'b1) begin
        d = cur_delay;
        if (d >= 1) begin
          repeat (d) @(posedge clk);
          #1 i2c_complete = 1'b1;
          @(posedge clk);
          #1 i2c_complete = 1'b0;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    job_t         cj;
    bit           active;
    int           cyc;
    int           t_hs;
    int           t_en;
    int           n_en;
    logic [103:0] prev_frame;
    logic [1:0]   prev_status;
    active = 1'b0; cyc = 0; t_hs = 0; t_en = 0; n_en = 0;
    prev_frame = '0; prev_status = 2'b00;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        active = 1'b0; prev_frame = '0; prev_status = 2'b00;
      end else begin
        if ((req_ready & req_valid) != 2'b00) begin
          check("no_overlap", active, 0);
          if (exp_q.size() == 0) begin
            check("handshake_expected", 0, 1);
          end else begin
            cj = exp_q.pop_front();
            check("grant", req_ready, 2'b01 << cj.id);
            check("status_held", status, prev_status);
            active = 1'b1; t_hs = cyc; n_en = 0;
          end
        end else if (active) begin
          check("busy_in_job", busy, 1);
        end
        if (i2c_enable) begin
          check("enable_in_job", active, 1);
          check("enable_with_ready", i2c_ready, 1);
          if (active) begin
            check("frame", i2c_frame, cj.frame);
            check("enable_time", cyc - t_hs, cj.en_off);
          end
          t_en = cyc; n_en++;
        end
        if (done) begin
          check("done_in_job", active, 1);
          if (active) begin
            check("done_id", done_id, cj.id);
            check("status", status, cj.status);
            if (cj.op == 2'b11) begin
              check("badop_no_enable", n_en, 0);
              check("badop_done_time", cyc - t_hs, 1);
              check("badop_frame_held", i2c_frame, prev_frame);
            end else begin
              check("one_enable", n_en, 1);
              if (cj.status == 2'b00) check("done_time", cyc - t_en, cj.delay + 1);
              else                    check("timeout_time", cyc - t_en, TIMEOUT);
              prev_frame = cj.frame;
            end
            prev_status = cj.status;
            active = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit seen;
    req_valid = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {req_ready, i2c_enable, done, busy, status, done_id, fp_op}, 0);
    check("reset_fp", {fp_a, fp_b}, 0);
    check("reset_frame", i2c_frame, 0);
    req_valid = 2'b00;
    reset = 1'b0;

    // both requesters valid continuously: grants alternate 0,1,0,1
    rand_cmd(0);
    rand_cmd(1);
    for (int k = 0; k < 4; k++) begin
      run_round();
      if (!pend[0]) rand_cmd(0);
      if (!pend[1]) rand_cmd(1);
    end
    drain();

    // directed 1.0 + 2.0 job, complete 10 cycles after launch
    new_cmd(0, 2'b00, 32'h3F800000, 32'h40000000, 10, 0);
    run_round();
    check("t1_frame_literal", i2c_frame, 104'hFC_3F800000_40000000_40400000);

    // bad opcode from requester 1
    new_cmd(1, 2'b11, $urandom, $urandom, 5, 0);
    run_round();

    // timeout, then next request accepted
    new_cmd(0, 2'b00, $urandom, $urandom, -1, 0);
    run_round();
    new_cmd(1, 2'b01, $urandom, $urandom, 3, 0);
    run_round();

    // complete on the timeout cycle wins; complete one cycle late loses
    new_cmd(0, 2'b10, $urandom, $urandom, TIMEOUT - 1, 0);
    run_round();
    new_cmd(0, 2'b00, $urandom, $urandom, TIMEOUT, 0);
    run_round();

    // i2c_ready held low for 20 cycles of SEND
    new_cmd(1, 2'b10, $urandom, $urandom, 4, 20);
    run_round();

    // randomized traffic
    repeat (40) begin
      for (int i = 0; i < 2; i++) if (!pend[i] && $urandom_range(0, 2) != 0) rand_cmd(i);
      if (!pend[0] && !pend[1]) rand_cmd(int'($urandom_range(0, 1)));
      run_round();
    end
    drain();

    // reset in WAIT_CMPL aborts the job silently
    new_cmd(1, 2'b01, $urandom, $urandom, -1, 0);
    issue_job();
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (i2c_enable) seen = 1'b1;
    end
    check("reset_job_enable_seen", seen, 1);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midjob_reset_ctrl", {req_ready, i2c_enable, done, busy, status, done_id, fp_op}, 0);
    check("midjob_reset_fp", {fp_a, fp_b}, 0);
    check("midjob_reset_frame", i2c_frame, 0);
    mlast = 1'b1;
    rand_cmd(0);
    rand_cmd(1);
    drive_reqs();
    repeat (2) begin
      @(negedge clk);
      check("reset_no_done", {done, req_ready}, 0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    run_round();
    drain();

    repeat (5) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    finish_tb();
  end

endmodule
